// File: rtl/rf_writeback_arbiter_pkg.sv
// Purpose: shared types and constants for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   REG_ADDR_W / NUM_REGS : register address width and register count
//   src_e                 : which requester drives the write port in a cycle
//   popcount              : number of set bits in a scoreboard vector
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MD   = 2'd2
  } src_e;

  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Purpose: bundles WB, MDU, decode and reg-file write-port signals of the arbiter.
// Latency: n/a (wires only).
// Backpressure: MD_READY throttles MDU results; WB is never throttled.
//   master : environment side (drives requests, observes RF_* / STALL / ERR)
//   slave  : arbiter side
interface rf_writeback_arbiter_if #(
  parameter int DATA_W = 32
);
  import rf_arb_pkg::*;

  logic              WB_VALID;
  reg_addr_t         WB_ADDR;
  logic [DATA_W-1:0] WB_DATA;
  logic              MD_ISSUE;
  reg_addr_t         MD_ISSUE_ADDR;
  logic              MD_VALID;
  reg_addr_t         MD_ADDR;
  logic [DATA_W-1:0] MD_DATA;
  logic              MD_READY;
  logic              ID_VALID;
  reg_addr_t         ID_RS1;
  reg_addr_t         ID_RS2;
  reg_addr_t         ID_RD;
  logic              ID_USES_RS1;
  logic              ID_USES_RS2;
  logic              ID_WRITES_RD;
  logic              STALL;
  logic              RF_WRITE;
  reg_addr_t         RF_INADDRESS;
  logic [DATA_W-1:0] RF_IN;
  logic [5:0]        PENDING_CNT;
  logic              ERR;

  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, MD_ISSUE, MD_ISSUE_ADDR,
           MD_VALID, MD_ADDR, MD_DATA, ID_VALID, ID_RS1, ID_RS2, ID_RD,
           ID_USES_RS1, ID_USES_RS2, ID_WRITES_RD,
    input  MD_READY, STALL, RF_WRITE, RF_INADDRESS, RF_IN, PENDING_CNT, ERR
  );

  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, MD_ISSUE, MD_ISSUE_ADDR,
           MD_VALID, MD_ADDR, MD_DATA, ID_VALID, ID_RS1, ID_RS2, ID_RD,
           ID_USES_RS1, ID_USES_RS2, ID_WRITES_RD,
    output MD_READY, STALL, RF_WRITE, RF_INADDRESS, RF_IN, PENDING_CNT, ERR
  );

endinterface

// File: rtl/rf_writeback_arbiter_fifo.sv
// Purpose: small synchronous FIFO holding MDU results that lost the write port.
// Latency: head visible the cycle after push into an empty FIFO.
// Backpressure: full deasserts the producer's ready; push when full is ignored.
//   clk, rst_n          : clock, async active-low reset (clears pointers)
//   push/push_data      : enqueue
//   pop/pop_data        : dequeue / current head
//   full, empty         : occupancy flags
module rf_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty.
  logic [AW:0] wr_ptr, rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Purpose: arbitrates the single reg-file write port between WB and MDU, tracks MDU hazards.
// Latency: 1 cycle from selected request to RF_*; STALL is combinational.
// Backpressure: MD_READY low while the result FIFO is full; WB always wins the port.
//   CLK, RESET : clock, async active-low reset
//   bus        : WB / MDU / decode inputs; RF_*, STALL, MD_READY, PENDING_CNT, ERR outputs
module rf_writeback_arbiter
  import rf_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  rf_writeback_arbiter_if.slave bus
);
  // FIFO entry layout is {addr, data}.
  typedef struct packed {
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  entry_t            fifo_in, fifo_head;
  logic              md_accept, wb_take, md_take;
  src_e              sel;
  reg_addr_t         sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [NUM_REGS-1:0] pending, pending_nxt, set_mask, clr_mask;
  logic                rf_write_q, rf_from_md_q, err_q, err_set;
  reg_addr_t           rf_addr_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic [5:0]          cnt_q;

  assign md_accept = bus.MD_VALID & ~fifo_full;
  assign wb_take   = bus.WB_VALID & (bus.WB_ADDR != '0);
  // x0 results are accepted from the MDU but dropped here.
  assign md_take   = md_accept & (bus.MD_ADDR != '0);
  assign fifo_in   = {bus.MD_ADDR, bus.MD_DATA};

  rf_result_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Port selection: WB, then buffered MDU results (oldest first), then MDU bypass.
  always_comb begin
    sel       = SRC_NONE;
    sel_addr  = fifo_head.addr;
    sel_data  = fifo_head.data;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    if (wb_take) begin
      sel       = SRC_WB;
      sel_addr  = bus.WB_ADDR;
      sel_data  = bus.WB_DATA;
      fifo_push = md_take;
    end else if (!fifo_empty) begin
      sel       = SRC_MD;
      fifo_pop  = 1'b1;
      fifo_push = md_take;
    end else if (md_take) begin
      sel      = SRC_MD;
      sel_addr = bus.MD_ADDR;
      sel_data = bus.MD_DATA;
    end
  end

  // Clear comes from the write currently presented to reg_file; a same-edge
  // issue to that register re-sets the bit, so set is applied last.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (rf_write_q && rf_from_md_q) clr_mask[rf_addr_q] = 1'b1;
    if (bus.MD_ISSUE && (bus.MD_ISSUE_ADDR != '0)) set_mask[bus.MD_ISSUE_ADDR] = 1'b1;
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // Re-issue to a register whose result is still outstanding, an MDU result with
  // no outstanding issue, or a WB write racing an MDU result are all protocol errors.
  assign err_set = (|(set_mask & pending & ~clr_mask))
                 | (md_take & ~pending[bus.MD_ADDR])
                 | (wb_take & pending[bus.WB_ADDR]);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rf_write_q   <= 1'b0;
      rf_from_md_q <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      pending      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      rf_write_q   <= (sel != SRC_NONE);
      rf_from_md_q <= (sel == SRC_MD);
      if (sel != SRC_NONE) begin
        rf_addr_q <= sel_addr;
        rf_data_q <= sel_data;
      end
      pending <= pending_nxt;
      cnt_q   <= popcount(pending_nxt);
      err_q   <= err_q | err_set;
    end
  end

  assign bus.MD_READY     = ~fifo_full;
  assign bus.STALL        = bus.ID_VALID & ((bus.ID_USES_RS1  & pending[bus.ID_RS1])
                                          | (bus.ID_USES_RS2  & pending[bus.ID_RS2])
                                          | (bus.ID_WRITES_RD & pending[bus.ID_RD]));
  assign bus.RF_WRITE     = rf_write_q;
  assign bus.RF_INADDRESS = rf_addr_q;
  assign bus.RF_IN        = rf_data_q;
  assign bus.PENDING_CNT  = cnt_q;
  assign bus.ERR          = err_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Purpose: self-checking bench for rf_writeback_arbiter (directed table + random vs reference model).
// Latency: checks comb outputs before each edge, registered outputs 1 time unit after it.
// Backpressure: model tracks FIFO occupancy to predict MD_READY.
module tb_rf_writeback_arbiter;
  localparam int DEPTH = 2;
  localparam int DW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.DATA_W(DW)) bus();

  rf_writeback_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit [4:0] a; bit [31:0] d; } ent_t;
  bit        m_pend [32];
  ent_t      m_q [$];
  bit        m_wr, m_md, m_err;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  int        m_cnt;

  function automatic void m_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_q.delete();
    m_wr = 0; m_md = 0; m_err = 0; m_addr = 0; m_data = 0; m_cnt = 0;
  endfunction

  function automatic bit m_ready();
    return m_q.size() < DEPTH;
  endfunction

  function automatic bit m_stall();
    return bus.ID_VALID && ((bus.ID_USES_RS1 && m_pend[bus.ID_RS1]) ||
                            (bus.ID_USES_RS2 && m_pend[bus.ID_RS2]) ||
                            (bus.ID_WRITES_RD && m_pend[bus.ID_RD]));
  endfunction

  // One clock edge: what reg_file sees next, and how the scoreboard changes.
  function automatic void m_step();
    bit   newp [32];
    bit   acc, md_ok, direct;
    ent_t e;
    acc   = bus.MD_VALID && m_ready();
    md_ok = acc && (bus.MD_ADDR != 0);
    newp  = m_pend;
    if (m_wr && m_md) newp[m_addr] = 0;
    if (bus.MD_ISSUE && bus.MD_ISSUE_ADDR != 0) begin
      if (newp[bus.MD_ISSUE_ADDR]) m_err = 1;
      newp[bus.MD_ISSUE_ADDR] = 1;
    end
    if (md_ok && !m_pend[bus.MD_ADDR]) m_err = 1;
    if (bus.WB_VALID && bus.WB_ADDR != 0 && m_pend[bus.WB_ADDR]) m_err = 1;
    direct = 0;
    if (bus.WB_VALID && bus.WB_ADDR != 0) begin
      m_wr = 1; m_md = 0; m_addr = bus.WB_ADDR; m_data = bus.WB_DATA;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_wr = 1; m_md = 1; m_addr = e.a; m_data = e.d;
    end else if (md_ok) begin
      m_wr = 1; m_md = 1; m_addr = bus.MD_ADDR; m_data = bus.MD_DATA; direct = 1;
    end else begin
      m_wr = 0; m_md = 0;
    end
    if (md_ok && !direct) begin
      e.a = bus.MD_ADDR; e.d = bus.MD_DATA;
      m_q.push_back(e);
    end
    m_pend  = newp;
    m_pend[0] = 0;
    m_cnt = 0;
    foreach (m_pend[i]) m_cnt += int'(m_pend[i]);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit wbv; bit [4:0] wba; bit [31:0] wbd;
    bit iss; bit [4:0] issa;
    bit mdv; bit [4:0] mda; bit [31:0] mdd;
    bit idv; bit [4:0] rs2;
    bit e_rdy; bit e_stall;
    bit e_wr; bit [4:0] e_a; bit [31:0] e_d;
    bit [5:0] e_cnt; bit e_err;
  } vec_t;

  function automatic vec_t mk(bit wbv, bit [4:0] wba, bit [31:0] wbd, bit iss, bit [4:0] issa,
                              bit mdv, bit [4:0] mda, bit [31:0] mdd, bit idv, bit [4:0] rs2,
                              bit e_rdy, bit e_stall, bit e_wr, bit [4:0] e_a, bit [31:0] e_d,
                              bit [5:0] e_cnt, bit e_err);
    vec_t v;
    v.wbv = wbv; v.wba = wba; v.wbd = wbd; v.iss = iss; v.issa = issa;
    v.mdv = mdv; v.mda = mda; v.mdd = mdd; v.idv = idv; v.rs2 = rs2;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_wr = e_wr; v.e_a = e_a; v.e_d = e_d;
    v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive_idle();
    bus.WB_VALID = 0; bus.WB_ADDR = 0; bus.WB_DATA = 0;
    bus.MD_ISSUE = 0; bus.MD_ISSUE_ADDR = 0;
    bus.MD_VALID = 0; bus.MD_ADDR = 0; bus.MD_DATA = 0;
    bus.ID_VALID = 0; bus.ID_RS1 = 0; bus.ID_RS2 = 0; bus.ID_RD = 0;
    bus.ID_USES_RS1 = 0; bus.ID_USES_RS2 = 0; bus.ID_WRITES_RD = 0;
  endtask

  task automatic drive_random();
    bus.WB_VALID = ($urandom_range(0, 2) == 0); bus.WB_ADDR = 5'($urandom_range(0, 7));
    bus.WB_DATA = $urandom;
    bus.MD_ISSUE = ($urandom_range(0, 2) == 0); bus.MD_ISSUE_ADDR = 5'($urandom_range(0, 7));
    bus.MD_VALID = ($urandom_range(0, 1) == 0); bus.MD_ADDR = 5'($urandom_range(0, 7));
    bus.MD_DATA = $urandom;
    bus.ID_VALID = 1'($urandom); bus.ID_RS1 = 5'($urandom_range(0, 7));
    bus.ID_RS2 = 5'($urandom_range(0, 7)); bus.ID_RD = 5'($urandom_range(0, 7));
    bus.ID_USES_RS1 = 1'($urandom); bus.ID_USES_RS2 = 1'($urandom);
    bus.ID_WRITES_RD = 1'($urandom);
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic run_cycle(input bit has_exp, input vec_t v, input int idx);
    #1;
    check("md_ready_model", bus.MD_READY, m_ready());
    check("stall_model", bus.STALL, m_stall());
    if (has_exp) begin
      check($sformatf("md_ready_row%0d", idx), bus.MD_READY, v.e_rdy);
      check($sformatf("stall_row%0d", idx), bus.STALL, v.e_stall);
    end
    @(posedge clk);
    m_step();
    #1;
    check("rf_write_model", bus.RF_WRITE, m_wr);
    check("rf_addr_model", bus.RF_INADDRESS, m_addr);
    check("rf_in_model", bus.RF_IN, m_data);
    check("pending_cnt_model", bus.PENDING_CNT, m_cnt);
    check("err_model", bus.ERR, m_err);
    if (has_exp) begin
      check($sformatf("rf_write_row%0d", idx), bus.RF_WRITE, v.e_wr);
      if (v.e_wr) begin
        check($sformatf("rf_addr_row%0d", idx), bus.RF_INADDRESS, v.e_a);
        check($sformatf("rf_in_row%0d", idx), bus.RF_IN, v.e_d);
      end
      check($sformatf("pending_cnt_row%0d", idx), bus.PENDING_CNT, v.e_cnt);
      check($sformatf("err_row%0d", idx), bus.ERR, v.e_err);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rf_write"}, bus.RF_WRITE, 0);
    check({tag, "_rf_addr"}, bus.RF_INADDRESS, 0);
    check({tag, "_rf_in"}, bus.RF_IN, 0);
    check({tag, "_pending_cnt"}, bus.PENDING_CNT, 0);
    check({tag, "_err"}, bus.ERR, 0);
    check({tag, "_md_ready"}, bus.MD_READY, 1);
  endtask

  vec_t tbl [$];
  vec_t none;

  initial begin
    none = mk(0,0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0);
    //          wbv wba wbd          iss issa mdv mda mdd          idv rs2 rdy stl wr a  d            cnt err
    tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,            0, 0, 1, 0, 1, 5, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, 0, 32'h1,        0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 7, 0, 0, 0,            1, 7, 1, 0, 0, 0, 0,            1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            1, 7, 1, 1, 0, 0, 0,            1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 1, 7, 32'h12345678, 1, 7, 1, 1, 1, 7, 32'h12345678, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            1, 7, 1, 1, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            1, 7, 1, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 3, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            1, 0));
    tbl.push_back(mk(0, 0, 0,            1, 4, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            2, 0));
    tbl.push_back(mk(1, 10, 32'hA0,      0, 0, 1, 3, 32'hD3,       0, 0, 1, 0, 1, 10, 32'hA0,      2, 0));
    tbl.push_back(mk(1, 11, 32'hA1,      0, 0, 1, 4, 32'hD4,       0, 0, 1, 0, 1, 11, 32'hA1,      2, 0));
    tbl.push_back(mk(1, 12, 32'hA2,      0, 0, 1, 5, 32'hD5,       0, 0, 0, 0, 1, 12, 32'hA2,      2, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 3, 32'hD3,       2, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 1, 0, 1, 4, 32'hD4,       1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mk(0, 0, 0,            1, 9, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 1, 9, 32'hD9,       0, 0, 1, 0, 1, 9, 32'hD9,       1, 0));
    tbl.push_back(mk(0, 0, 0,            1, 9, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            1, 9, 1, 1, 0, 0, 0,            1, 0));
    tbl.push_back(mk(0, 0, 0,            1, 2, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            2, 0));
    tbl.push_back(mk(0, 0, 0,            1, 2, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            2, 1));
    tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0,            2, 1));

    // Reset held for two cycles under random inputs.
    m_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      @(negedge clk);
      check_reset_vals("reset");
    end
    drive_idle();
    rst_n = 1'b1;
    #1;
    check("post_reset_md_ready", bus.MD_READY, 1);
    check("post_reset_stall", bus.STALL, 0);
    @(negedge clk);

    // Directed sequence: WB path, stall lifetime, FIFO conflict, set-wins, sticky error.
    for (int i = 0; i < tbl.size(); i++) begin
      drive_idle();
      bus.WB_VALID = tbl[i].wbv; bus.WB_ADDR = tbl[i].wba; bus.WB_DATA = tbl[i].wbd;
      bus.MD_ISSUE = tbl[i].iss; bus.MD_ISSUE_ADDR = tbl[i].issa;
      bus.MD_VALID = tbl[i].mdv; bus.MD_ADDR = tbl[i].mda; bus.MD_DATA = tbl[i].mdd;
      bus.ID_VALID = tbl[i].idv; bus.ID_RS2 = tbl[i].rs2; bus.ID_USES_RS2 = tbl[i].idv;
      run_cycle(1'b1, tbl[i], i);
    end

    // Mid-operation async reset: pending bits and ERR are set at this point.
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the reference model, with one more async reset midway.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        drive_random();
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("rand_reset");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive_random();
      run_cycle(1'b0, none, i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the single register-file write port (IN/INADDRESS/WRITE) between the fixed-latency pipeline writeback stage and the multi-cycle MUL/DIV unit (MDU).
- Keeps a 32-entry scoreboard of registers with outstanding MDU results.
- Raises a decode-stage stall on RAW/WAW hazards against those registers.
- Sits between the WB stage, the MDU and reg_file; all reg-file write-port signals come from this block.

Parameters:
- FIFO_DEPTH, 2, number of MDU results buffered while the WB stage owns the port (power of two, >=2)
- DATA_W, 32, register data width

Ports:
- CLK  in  1  clock, all state on posedge
- RESET  in  1  asynchronous, active-low reset
- WB_VALID  in  1  pipeline writeback request (never back-pressured)
- WB_ADDR  in  5  pipeline destination register
- WB_DATA  in  DATA_W  pipeline writeback value
- MD_ISSUE  in  1  MDU op issued this cycle
- MD_ISSUE_ADDR  in  5  destination of issued MDU op
- MD_VALID  in  1  MDU result valid
- MD_ADDR  in  5  MDU result destination
- MD_DATA  in  DATA_W  MDU result value
- MD_READY  out  1  result accepted when MD_VALID & MD_READY
- ID_VALID  in  1  decode stage holds an instruction
- ID_RS1, ID_RS2, ID_RD  in  5 each  decode operand and destination addresses
- ID_USES_RS1, ID_USES_RS2, ID_WRITES_RD  in  1 each  operand/destination qualifiers
- STALL  out  1  hold decode (combinational)
- RF_WRITE  out  1  to reg_file WRITE (registered)
- RF_INADDRESS  out  5  to reg_file INADDRESS (registered)
- RF_IN  out  DATA_W  to reg_file IN (registered)
- PENDING_CNT  out  6  number of set scoreboard bits
- ERR  out  1  sticky protocol error

Behaviour:
- Reset (RESET=0, async): RF_WRITE=0, RF_INADDRESS=0, RF_IN=0, FIFO empty, scoreboard clear, PENDING_CNT=0, ERR=0. MD_READY=1 and STALL=0 once reset is released.
- Writes to x0 are dropped: a WB or MD request with addr 0 never asserts RF_WRITE. An MDU issue to x0 never sets a scoreboard bit.
- Port selection, evaluated each cycle and registered into RF_* at the next posedge (1-cycle latency):
  - Priority 1: WB_VALID & WB_ADDR!=0 → WB_ADDR/WB_DATA.
  - Priority 2: FIFO non-empty → FIFO head (popped).
  - Priority 3: MD bypass, when the FIFO is empty and an MD result is accepted this cycle → MD_ADDR/MD_DATA directly.
  - Otherwise RF_WRITE=0; RF_INADDRESS and RF_IN hold their values.
- An accepted MD result that is not selected is pushed into the FIFO.
- MD_READY = !FIFO full. Simultaneous push and pop on a full FIFO is not allowed; READY already excludes it.
- Scoreboard:
  - Set pending[MD_ISSUE_ADDR] on MD_ISSUE.
  - Clear pending[a] at the posedge ending a cycle in which RF_WRITE=1 with an MD-sourced entry for a, i.e. the edge on which reg_file samples it.
  - Set and clear of the same address on the same edge → set wins.
  - MD_ISSUE to an already-pending address → ERR=1 (sticky); the bit stays set.
  - An MD result for a non-pending address → ERR=1; the write still proceeds.
- STALL = ID_VALID & ((ID_USES_RS1 & pending[ID_RS1]) | (ID_USES_RS2 & pending[ID_RS2]) | (ID_WRITES_RD & pending[ID_RD])). pending[0] is always 0.
- PENDING_CNT is the registered popcount of the scoreboard and is updated on the same edge as the bits.
- A WB write to a pending register cannot occur (WAW stall). If it does, ERR=1 and the write proceeds.
- Reset mid-operation discards FIFO contents and pending bits; the MDU is reset by the same RESET.

Decomposition:
- Shared package rf_arb_pkg:
  - REG_ADDR_W=5, NUM_REGS=32
  - source encoding SRC_NONE/SRC_WB/SRC_MD (2 bits)
  - struct/concat layout {addr, data} for FIFO entries
- One sub-module: rf_result_fifo, a parameterised synchronous FIFO (push/pop/full/empty, async active-low reset).
- Scoreboard and selection logic stay in the top module.

Test Plan:
- Reset: hold RESET=0 two cycles with random inputs → RF_WRITE=0, PENDING_CNT=0, MD_READY=1, ERR=0.
- WB path: WB_VALID=1, WB_ADDR=5, WB_DATA=0xDEADBEEF → next cycle RF_WRITE=1, RF_INADDRESS=5, RF_IN=0xDEADBEEF. WB_ADDR=0 → RF_WRITE stays 0.
- Scoreboard/stall: MD_ISSUE to x7; decode ID_RS2=7 with ID_USES_RS2 → STALL=1 until MD result (x7, 0x12345678) is written. STALL falls the cycle after RF_WRITE=1/RF_INADDRESS=7; PENDING_CNT goes 1→0.
- Conflict: WB_VALID for three consecutive cycles while MD results for x3 then x4 arrive → FIFO fills, MD_READY=0 on the third result. x3 and x4 are written in order immediately after the WB burst.
- Set-wins: MD_ISSUE x9 on the same cycle the previous x9 MD result is written → pending[9] stays 1, ERR=0.
- Errors: MD_ISSUE x2 twice without a result → ERR=1 and it stays 1 until RESET.
